// File: rtl/watchdog_reset_req_pkg.sv
// Shared definitions for the watchdog reset initiator: bus word offsets, kick key and FSM encodings.
// HALT reuses the BITE status code; bit 2 of the state is the internal halt flag.
package watchdog_reset_req_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_RELOAD = 2'd1;
    localparam logic [1:0] ADDR_KICK   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_LOCK_BIT   = 1;
    localparam int STATUS_BITTEN_BIT = 0;

    localparam logic [31:0] KICK_KEY = 32'h5A5A_5A5A;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b000,
        ST_RUN  = 3'b001,
        ST_WARN = 3'b010,
        ST_BITE = 3'b011,
        ST_HALT = 3'b111
    } wdt_state_e;

    // Two-bit code exposed in STATUS[2:1]; BITE and HALT both report 2'b11.
    function automatic logic [1:0] status_code(input wdt_state_e s);
        logic [2:0] v;
        v = s;
        return v[1:0];
    endfunction

endpackage

// File: rtl/watchdog_reset_req_prescaler.sv
// Watchdog tick prescaler: free-runs 0..PRESCALE-1 while enabled and emits a one-cycle tick
// on the last count. A clear restarts the phase so the next tick is a full period away.
module wdt_prescaler #(
    parameter int PRESCALE = 24000
) (
    input  logic clock_in,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt;

    assign tick = run && (cnt == LAST);

    always_ff @(posedge clock_in) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= tick ? '0 : cnt + PW'(1);
        end
    end

endmodule

// File: rtl/watchdog_reset_req.sv
// Memory-mapped watchdog that raises an IRQ on a missed deadline and requests a SoC reset on
// the second miss. Optional window mode (too-early kick bites) is enabled by defining WDT_WINDOW_EN.
module watchdog_reset_req
    import watchdog_reset_req_pkg::*;
#(
    parameter int PRESCALE    = 24000,
    parameter int COUNTER_W   = 16,
    parameter int BITE_CYCLES = 16
) (
    input  logic        clock_in,
    input  logic        reset,
    input  logic [1:0]  io_addr,
    input  logic [31:0] io_wdata,
    input  logic        io_wstrb,
    input  logic        io_rstrb,
    output logic [31:0] io_rdata,
    output logic        wdt_irq,
    output logic        wdt_bite_n
);

    localparam int BW = (BITE_CYCLES > 1) ? $clog2(BITE_CYCLES) : 1;
    localparam logic [BW-1:0]        BITE_LAST = BW'(BITE_CYCLES - 1);
    localparam logic [COUNTER_W-1:0] CNT_ONE   = COUNTER_W'(1);

    function automatic logic [COUNTER_W-1:0] reload_floor(input logic [COUNTER_W-1:0] r);
        return (r == '0) ? CNT_ONE : r;
    endfunction

    logic                 ctrl_enable;
    logic                 ctrl_lock;
    logic [COUNTER_W-1:0] reload_reg;
    logic [COUNTER_W-1:0] reload_eff;
    logic [COUNTER_W-1:0] count;
    logic [COUNTER_W-1:0] count_nx;
    logic [BW-1:0]        bite_cnt;
    logic [BW-1:0]        bite_cnt_nx;
    wdt_state_e           state;
    wdt_state_e           state_nx;
    logic                 irq_nx;
    logic                 enter_bite;

    // Survives reset on purpose so firmware can see that the last restart was a watchdog bite.
    logic                 bitten = 1'b0;

    logic wr_ctrl;
    logic wr_reload;
    logic wr_status;
    logic kick_valid;
    logic kick;
    logic early_kick;
    logic tick;
    logic psc_run;
    logic psc_clear;
    logic [31:0] rdata_nx;

    assign reload_eff = reload_floor(reload_reg);

    assign wr_ctrl    = io_wstrb && (io_addr == ADDR_CTRL) && !ctrl_lock;
    assign wr_reload  = io_wstrb && (io_addr == ADDR_RELOAD);
    assign wr_status  = io_wstrb && (io_addr == ADDR_STATUS);
    assign kick_valid = io_wstrb && (io_addr == ADDR_KICK) && (io_wdata == KICK_KEY);
    assign kick       = kick_valid && ((state == ST_RUN) || (state == ST_WARN));

`ifdef WDT_WINDOW_EN
    assign early_kick = kick && (state == ST_RUN) && (count > (reload_eff >> 1));
`else
    assign early_kick = 1'b0;
`endif

    assign psc_run = (state == ST_RUN) || (state == ST_WARN);

    wdt_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clock_in (clock_in),
        .reset    (reset),
        .run      (psc_run),
        .clear    (psc_clear),
        .tick     (tick)
    );

    always_comb begin
        state_nx    = state;
        count_nx    = count;
        irq_nx      = wdt_irq;
        bite_cnt_nx = bite_cnt;
        psc_clear   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (ctrl_enable) begin
                    state_nx  = ST_RUN;
                    count_nx  = reload_eff;
                    psc_clear = 1'b1;
                end
            end
            ST_RUN, ST_WARN: begin
                if (!ctrl_enable) begin
                    state_nx = ST_IDLE;
                    irq_nx   = 1'b0;
                end else if (early_kick) begin
                    state_nx    = ST_BITE;
                    bite_cnt_nx = '0;
                end else if (kick) begin
                    // A kick outranks a coincident terminal tick.
                    state_nx  = ST_RUN;
                    count_nx  = reload_eff;
                    irq_nx    = 1'b0;
                    psc_clear = 1'b1;
                end else if (tick) begin
                    if (count == CNT_ONE) begin
                        if (state == ST_RUN) begin
                            state_nx = ST_WARN;
                            count_nx = reload_eff;
                            irq_nx   = 1'b1;
                        end else begin
                            state_nx    = ST_BITE;
                            bite_cnt_nx = '0;
                        end
                    end else begin
                        count_nx = count - CNT_ONE;
                    end
                end
            end
            ST_BITE: begin
                // Not abortable by enable=0; only reset cuts the pulse short.
                if (bite_cnt == BITE_LAST) begin
                    state_nx = ST_HALT;
                end else begin
                    bite_cnt_nx = bite_cnt + BW'(1);
                end
            end
            ST_HALT: begin
                if (!ctrl_enable) begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    assign enter_bite = !reset && (state_nx == ST_BITE) && (state != ST_BITE);

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state      <= ST_IDLE;
            count      <= '1;
            bite_cnt   <= '0;
            wdt_irq    <= 1'b0;
            wdt_bite_n <= 1'b1;
        end else begin
            state      <= state_nx;
            count      <= count_nx;
            bite_cnt   <= bite_cnt_nx;
            wdt_irq    <= irq_nx;
            wdt_bite_n <= (state_nx != ST_BITE);
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            ctrl_enable <= 1'b0;
            ctrl_lock   <= 1'b0;
            reload_reg  <= '1;
        end else begin
            if (wr_ctrl) begin
                ctrl_enable <= io_wdata[CTRL_ENABLE_BIT];
                ctrl_lock   <= io_wdata[CTRL_LOCK_BIT];
            end
            if (wr_reload) begin
                reload_reg <= io_wdata[COUNTER_W-1:0];
            end
        end
    end

    always_ff @(posedge clock_in) begin
        if (enter_bite) begin
            bitten <= 1'b1;
        end else if (wr_status && io_wdata[STATUS_BITTEN_BIT]) begin
            bitten <= 1'b0;
        end
    end

    always_comb begin
        rdata_nx = '0;
        unique case (io_addr)
            ADDR_CTRL: begin
                rdata_nx[CTRL_ENABLE_BIT] = ctrl_enable;
                rdata_nx[CTRL_LOCK_BIT]   = ctrl_lock;
            end
            ADDR_RELOAD: begin
                rdata_nx[COUNTER_W-1:0] = reload_reg;
            end
            ADDR_STATUS: begin
                rdata_nx[31:16]             = 16'(count);
                rdata_nx[2:1]               = status_code(state);
                rdata_nx[STATUS_BITTEN_BIT] = bitten;
            end
            default: begin
                rdata_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            io_rdata <= '0;
        end else if (io_rstrb) begin
            io_rdata <= rdata_nx;
        end
    end

endmodule

// File: tb/tb_watchdog_reset_req.sv
// Directed bench for watchdog_reset_req with PRESCALE=4, BITE_CYCLES=16: register table plus
// timing sequences for warn/bite, kicking, lock, reset during bite and the optional window mode.
module tb_watchdog_reset_req;

    localparam logic [31:0] KEY = 32'h5A5A_5A5A;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  io_addr = 2'd0;
    logic [31:0] io_wdata = 32'd0;
    logic        io_wstrb = 1'b0;
    logic        io_rstrb = 1'b0;
    logic [31:0] io_rdata;
    logic        wdt_irq;
    logic        wdt_bite_n;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    watchdog_reset_req #(
        .PRESCALE    (4),
        .COUNTER_W   (16),
        .BITE_CYCLES (16)
    ) dut (
        .clock_in   (clk),
        .reset      (reset),
        .io_addr    (io_addr),
        .io_wdata   (io_wdata),
        .io_wstrb   (io_wstrb),
        .io_rstrb   (io_rstrb),
        .io_rdata   (io_rdata),
        .wdt_irq    (wdt_irq),
        .wdt_bite_n (wdt_bite_n)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
        string       name;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick1();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        io_addr  = a;
        io_wdata = d;
        io_wstrb = 1'b1;
        tick1();
        io_wstrb = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a);
        io_addr  = a;
        io_rstrb = 1'b1;
        tick1();
        io_rstrb = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        io_wstrb = 1'b0;
        io_rstrb = 1'b0;
        tick1();
        tick1();
        reset = 1'b0;
    endtask

    // Reset, program RELOAD, enable; returns the cycle number of the enabling write edge.
    task automatic start_wdt(input logic [31:0] rl, input logic [31:0] ctrl, output int w);
        do_reset();
        bus_write(2'd1, rl);
        bus_write(2'd0, ctrl);
        w = cyc;
    endtask

    task automatic measure(input int w, output int irq_k, output int bite_k, output int bite_len);
        irq_k = -1;
        bite_k = -1;
        bite_len = 0;
        for (int i = 0; i < 120; i++) begin
            tick1();
            if (wdt_irq && irq_k < 0) irq_k = cyc - w;
            if (!wdt_bite_n) begin
                if (bite_k < 0) bite_k = cyc - w;
                bite_len++;
            end
        end
    endtask

    task automatic wait_until(input int target);
        for (int i = 0; i < 200 && cyc < target; i++) tick1();
    endtask

    initial begin
        #2ms;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        int irq_k, bite_k, bite_len;
        int seen_irq, seen_bite;
        int period;

        vecs[0]  = '{1'b0, 2'd0, 32'h0,         32'h0000_0000, "rst_ctrl"};
        vecs[1]  = '{1'b0, 2'd1, 32'h0,         32'h0000_FFFF, "rst_reload"};
        vecs[2]  = '{1'b0, 2'd3, 32'h0,         32'hFFFF_0000, "rst_status"};
        vecs[3]  = '{1'b1, 2'd1, 32'h0001_0005, 32'h0,         "wr_reload"};
        vecs[4]  = '{1'b0, 2'd1, 32'h0,         32'h0000_0005, "reload_trunc"};
        vecs[5]  = '{1'b0, 2'd2, 32'h0,         32'h0000_0000, "kick_reads0"};
        vecs[6]  = '{1'b1, 2'd0, 32'hFFFF_FFFC, 32'h0,         "wr_ctrl_hi"};
        vecs[7]  = '{1'b0, 2'd0, 32'h0,         32'h0000_0000, "ctrl_unmapped"};
        vecs[8]  = '{1'b1, 2'd0, 32'h0000_0001, 32'h0,         "wr_enable"};
        vecs[9]  = '{1'b0, 2'd3, 32'h0,         32'hFFFF_0000, "status_idle"};
        vecs[10] = '{1'b0, 2'd3, 32'h0,         32'h0005_0002, "status_run"};
        vecs[11] = '{1'b0, 2'd0, 32'h0,         32'h0000_0001, "ctrl_enabled"};
        vecs[12] = '{1'b1, 2'd0, 32'h0000_0000, 32'h0,         "wr_disable"};
        vecs[13] = '{1'b0, 2'd3, 32'h0,         32'h0005_0002, "status_run2"};
        vecs[14] = '{1'b0, 2'd3, 32'h0,         32'h0005_0000, "status_disabled"};
        vecs[15] = '{1'b1, 2'd1, 32'h0000_0000, 32'h0,         "wr_reload0"};
        vecs[16] = '{1'b0, 2'd1, 32'h0,         32'h0000_0000, "reload0_read"};

        do_reset();
        check("rst_rdata", io_rdata, 32'h0);
        check("rst_irq", {31'b0, wdt_irq}, 32'h0);
        check("rst_bite_n", {31'b0, wdt_bite_n}, 32'h1);

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].data);
            else begin
                bus_read(vecs[i].addr);
                check(vecs[i].name, io_rdata, vecs[i].exp);
            end
        end

        // No kick: warn after 12 ticks-worth of cycles, bite 12 later for 16 cycles, then HALT.
        start_wdt(32'd3, 32'd1, w);
        measure(w, irq_k, bite_k, bite_len);
        check("nokick_irq_cycle", irq_k, 32'd13);
        check("nokick_bite_cycle", bite_k, 32'd25);
        check("nokick_bite_len", bite_len, 32'd16);
        bus_read(2'd3);
        check("halt_status", {29'b0, io_rdata[2:0]}, 32'h7);
        bus_write(2'd2, KEY);
        tick1();
        check("rdata_held", {29'b0, io_rdata[2:0]}, 32'h7);
        check("halt_ignores_kick", {31'b0, wdt_bite_n}, 32'h1);
        bus_write(2'd3, 32'h1);
        bus_read(2'd3);
        check("bitten_cleared", {29'b0, io_rdata[2:0]}, 32'h6);
        bus_write(2'd0, 32'h0);
        tick1();
        bus_read(2'd3);
        check("halt_to_idle", {29'b0, io_rdata[2:0]}, 32'h0);

        // Wrong key is ignored: schedule identical to no kick.
        start_wdt(32'd3, 32'd1, w);
        tick1();
        tick1();
        bus_write(2'd2, 32'h1234_5678);
        measure(w, irq_k, bite_k, bite_len);
        check("badkey_irq_cycle", irq_k, 32'd13);
        check("badkey_bite_cycle", bite_k, 32'd25);
        bus_read(2'd3);
        check("badkey_bitten", {31'b0, io_rdata[0]}, 32'h1);

        // Regular kicking keeps both outputs quiet.
`ifdef WDT_WINDOW_EN
        period = 10;
`else
        period = 8;
`endif
        start_wdt(32'd3, 32'd1, w);
        seen_irq = 0;
        seen_bite = 0;
        for (int k = 0; k < 1000 / period; k++) begin
            bus_write(2'd2, KEY);
            if (wdt_irq) seen_irq++;
            if (!wdt_bite_n) seen_bite++;
            for (int j = 1; j < period; j++) begin
                tick1();
                if (wdt_irq) seen_irq++;
                if (!wdt_bite_n) seen_bite++;
            end
        end
        check("kicked_no_irq", seen_irq, 32'd0);
        check("kicked_no_bite", seen_bite, 32'd0);

        // Kick coinciding with the WARN terminal tick wins.
        start_wdt(32'd3, 32'd1, w);
        wait_until(w + 24);
        check("warn_before_kick", {31'b0, wdt_irq}, 32'h1);
        bus_write(2'd2, KEY);
        check("edge_kick_bite_n", {31'b0, wdt_bite_n}, 32'h1);
        check("edge_kick_irq", {31'b0, wdt_irq}, 32'h0);
        bus_read(2'd3);
        check("edge_kick_status", io_rdata & 32'hFFFF_FFFE, 32'h0003_0002);

        // RELOAD of 0 behaves as 1; disabling in WARN drops the IRQ and returns to IDLE.
        start_wdt(32'd0, 32'd1, w);
        irq_k = -1;
        for (int i = 0; i < 40 && irq_k < 0; i++) begin
            tick1();
            if (wdt_irq) irq_k = cyc - w;
        end
        check("reload0_irq_cycle", irq_k, 32'd5);
        bus_write(2'd0, 32'h0);
        tick1();
        check("disable_clears_irq", {31'b0, wdt_irq}, 32'h0);
        bus_read(2'd3);
        check("disable_idle", {29'b0, io_rdata[2:1], 1'b0}, 32'h0);

        // Lock holds enable; reset mid-bite releases bite_n at once and keeps bitten.
        start_wdt(32'd3, 32'd3, w);
        bus_write(2'd0, 32'h0);
        bus_read(2'd0);
        check("locked_ctrl", io_rdata, 32'h3);
        bite_k = -1;
        for (int i = 0; i < 60 && bite_k < 0; i++) begin
            tick1();
            if (!wdt_bite_n) bite_k = cyc - w;
        end
        check("locked_bite_cycle", bite_k, 32'd25);
        tick1();
        tick1();
        tick1();
        reset = 1'b1;
        tick1();
        check("midbite_reset_bite_n", {31'b0, wdt_bite_n}, 32'h1);
        reset = 1'b0;
        bus_read(2'd0);
        check("midbite_reset_ctrl", io_rdata, 32'h0);
        bus_read(2'd3);
        check("midbite_reset_status", io_rdata, 32'hFFFF_0001);

        // Early kick at count=7 with RELOAD=8; then a kick at count=3.
        start_wdt(32'd8, 32'd1, w);
        wait_until(w + 5);
        bus_write(2'd2, KEY);
`ifdef WDT_WINDOW_EN
        check("early_kick_bites", {31'b0, wdt_bite_n}, 32'h0);
`else
        check("early_kick_ok", {31'b0, wdt_bite_n}, 32'h1);
        bus_read(2'd3);
        check("early_kick_status", io_rdata & 32'hFFFF_FFFE, 32'h0008_0002);
`endif
        start_wdt(32'd8, 32'd1, w);
        wait_until(w + 21);
        bus_write(2'd2, KEY);
        check("late_kick_bite_n", {31'b0, wdt_bite_n}, 32'h1);
        bus_read(2'd3);
        check("late_kick_status", io_rdata & 32'hFFFF_FFFE, 32'h0008_0002);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
